// File: rtl/inst_fetch_ctrl.sv
// Fetch-stage controller: owns the PC and issues one ICache request at a time.
// It delivers 1- or 2-instruction packets to the buffer and redirects on flush.
module inst_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] flush_pc_i,
   input  logic        buffer_full_i,
   output logic        inst_req_o,
   output logic [31:0] inst_addr_o,
   input  logic        inst_addr_ok_i,
   input  logic        inst_data_ok_i,
   input  logic [31:0] inst_rdata1_i,
   input  logic [31:0] inst_rdata2_i,
   output logic [31:0] fetch_inst1_o,
   output logic [31:0] fetch_inst2_o,
   output logic [31:0] fetch_inst1_addr_o,
   output logic [31:0] fetch_inst2_addr_o,
   output logic        fetch_inst1_valid_o,
   output logic        fetch_inst2_valid_o
);

   localparam logic [1:0] S_REQ     = 2'd0;
   localparam logic [1:0] S_WAIT    = 2'd1;
   localparam logic [1:0] S_DISCARD = 2'd2;

   localparam logic [31:0] PC_INIT = RESET_PC & ~32'd3;

   logic [1:0]  state;
   logic [1:0]  state_d;
   logic [31:0] pc;
   logic [31:0] pc_d;
   logic [31:0] pc_step;
   logic [31:0] req_pc;
   logic        req_one;
   logic        req_q;
   logic        req_d;
   logic        acc;
   logic        deliver;

   assign acc     = (state == S_REQ) && req_q && inst_addr_ok_i;
   assign deliver = (state == S_WAIT) && inst_data_ok_i && !flush;
   assign pc_step = pc + (pc[2] ? 32'd4 : 32'd8);

   assign inst_req_o  = req_q;
   assign inst_addr_o = pc;

   always_comb begin
      state_d = state;
      pc_d    = pc;
      unique case (state)
         S_REQ: begin
            if (acc) begin
               state_d = flush ? S_DISCARD : S_WAIT;
               pc_d    = pc_step;
            end
         end
         S_WAIT: begin
            if (inst_data_ok_i)
               state_d = S_REQ;
            else if (flush)
               state_d = S_DISCARD;
         end
         S_DISCARD: begin
            if (inst_data_ok_i)
               state_d = S_REQ;
         end
         default: state_d = S_REQ;
      endcase
      if (flush)
         pc_d = flush_pc_i & ~32'd3;
      // a raised request holds until accepted; a new one waits for buffer room
      req_d = (state_d == S_REQ) && !flush &&
              (req_q ? !inst_addr_ok_i : !buffer_full_i);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state               <= S_REQ;
         pc                  <= PC_INIT;
         req_q               <= 1'b0;
         req_pc              <= 32'd0;
         req_one             <= 1'b0;
         fetch_inst1_o       <= 32'd0;
         fetch_inst2_o       <= 32'd0;
         fetch_inst1_addr_o  <= 32'd0;
         fetch_inst2_addr_o  <= 32'd0;
         fetch_inst1_valid_o <= 1'b0;
         fetch_inst2_valid_o <= 1'b0;
      end else begin
         state <= state_d;
         pc    <= pc_d;
         req_q <= req_d;
         if (acc) begin
            req_pc  <= pc;
            req_one <= pc[2];
         end
         fetch_inst1_valid_o <= deliver;
         fetch_inst2_valid_o <= deliver && !req_one;
         if (deliver) begin
            fetch_inst1_o      <= req_one ? inst_rdata2_i : inst_rdata1_i;
            fetch_inst2_o      <= inst_rdata2_i;
            fetch_inst1_addr_o <= req_pc;
            fetch_inst2_addr_o <= req_pc + 32'd4;
         end
      end
   end

endmodule
